reduce_sweep_ctrl: RTL

Self-checking sweep sequencer for the 4-input OR-reduction unit. On `start` it drives every operand value from 0 to 2^WIDTH-1 onto the unit's input and waits a programmable settle time. It then samples the unit's output and compares it against the expected OR of the operand bits. It counts mismatches, records the first failing vector, and reports pass/fail with a one-cycle `done` pulse. It sits between a top-level test harness and the combinational reduction datapath, replacing the delay-based behavioural bench with a synthesizable on-chip checker.

---
 rtl/reduce_sweep_ctrl_if.sv | 26 ++
 rtl/reduce_sweep_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/reduce_sweep_ctrl_if.sv
// rtl/reduce_sweep_ctrl_if.sv - harness/controller/datapath signal bundle for the OR-reduction sweep checker
interface reduce_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_count;
  logic [WIDTH-1:0] first_fail;
  logic             first_fail_valid;

  // master: harness side (issues start, returns the reduction unit output)
  modport master (
    output start, dut_y,
    input  dut_a, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  // slave: the sweep controller
  modport slave (
    input  start, dut_y,
    output dut_a, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/reduce_sweep_ctrl.sv
// rtl/reduce_sweep_ctrl.sv - exhaustive operand sweep with settle delay and OR-reduction result checking
module reduce_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  reduce_sweep_ctrl_if.slave  io_sweep
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int                CNT_W     = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [WIDTH-1:0] r_dut_a;
  logic [WIDTH:0]   r_err_count;
  logic [WIDTH-1:0] r_first_fail;
  logic             r_first_fail_valid;
  logic             r_pass;

  logic w_expected;
  logic w_mismatch;

  assign w_expected = |r_dut_a;
  // Case inequality so an undriven or X output from the unit is flagged, not masked
  assign w_mismatch = (io_sweep.dut_y !== w_expected);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state            <= ST_IDLE;
      r_wait_cnt         <= '0;
      r_dut_a            <= '0;
      r_err_count        <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_pass             <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_sweep.start) begin
            r_state            <= ST_WAIT;
            r_wait_cnt         <= '0;
            r_dut_a            <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + 1'b1;
            if (!r_first_fail_valid) begin
              r_first_fail       <= r_dut_a;
              r_first_fail_valid <= 1'b1;
            end
          end
          // All-ones is the final vector; the operand never wraps back to zero
          if (&r_dut_a) begin
            r_state <= ST_DONE;
          end else begin
            r_dut_a    <= r_dut_a + 1'b1;
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_DONE: begin
          r_pass  <= (r_err_count == '0);
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_sweep.dut_a            = r_dut_a;
  assign io_sweep.busy             = (r_state != ST_IDLE);
  assign io_sweep.done             = (r_state == ST_DONE);
  assign io_sweep.pass             = r_pass;
  assign io_sweep.err_count        = r_err_count;
  assign io_sweep.first_fail       = r_first_fail;
  assign io_sweep.first_fail_valid = r_first_fail_valid;
endmodule
